// File: rtl/regfile_wb_ctrl.sv
// Register-file write-side controller: round-robin arbitration of three
// result sources (ALU, LSU, MDU) onto the single register-file write port,
// plus a 32-entry pending-write scoreboard and a sticky orphan-write flag.
module regfile_wb_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_wd,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_wd,
  output logic            lsu_ready,
  input  logic            mdu_valid,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_wd,
  output logic            mdu_ready,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic [31:0]     busy,
  output logic            orphan_err
);

  // Source indices; index 3 is a never-valid filler so a 2-bit index is safe.
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_LSU = 2'd1;
  localparam logic [1:0] SRC_MDU = 2'd2;

  logic [1:0]      rr_last_q, rr_last_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;
  logic [31:0]     busy_q, busy_d;
  logic            orphan_q, orphan_d;

  logic [3:0]      src_vld;
  logic [1:0]      ord0, ord1, ord2;
  logic [1:0]      gnt_idx;
  logic            xfer;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_wd;
  logic            iss_fire;

  assign src_vld = {1'b0, mdu_valid, lsu_valid, alu_valid};

  // Priority order starts at the source after the last one granted.
  always_comb begin
    ord0 = SRC_ALU;
    ord1 = SRC_LSU;
    ord2 = SRC_MDU;
    case (rr_last_q)
      SRC_ALU: begin ord0 = SRC_LSU; ord1 = SRC_MDU; ord2 = SRC_ALU; end
      SRC_LSU: begin ord0 = SRC_MDU; ord1 = SRC_ALU; ord2 = SRC_LSU; end
      default: begin ord0 = SRC_ALU; ord1 = SRC_LSU; ord2 = SRC_MDU; end
    endcase
  end

  // Pick the first valid source in rotated order; grants depend only on valids.
  always_comb begin
    gnt_idx = SRC_ALU;
    xfer    = 1'b0;
    if (src_vld[ord0]) begin
      gnt_idx = ord0;
      xfer    = 1'b1;
    end else if (src_vld[ord1]) begin
      gnt_idx = ord1;
      xfer    = 1'b1;
    end else if (src_vld[ord2]) begin
      gnt_idx = ord2;
      xfer    = 1'b1;
    end
  end

  assign alu_ready = xfer && (gnt_idx == SRC_ALU);
  assign lsu_ready = xfer && (gnt_idx == SRC_LSU);
  assign mdu_ready = xfer && (gnt_idx == SRC_MDU);

  // Steer the granted source's destination and data toward the write port.
  always_comb begin
    sel_rd = alu_rd;
    sel_wd = alu_wd;
    case (gnt_idx)
      SRC_LSU: begin sel_rd = lsu_rd; sel_wd = lsu_wd; end
      SRC_MDU: begin sel_rd = mdu_rd; sel_wd = mdu_wd; end
      default: begin sel_rd = alu_rd; sel_wd = alu_wd; end
    endcase
  end

  // Issue may proceed when its destination is x0 or has nothing in flight.
  assign iss_ready = (iss_rd == 5'd0) || !busy_q[iss_rd];
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != 5'd0);

  // Next-state: write-port register, round-robin pointer, scoreboard, orphan flag.
  always_comb begin
    rr_last_d = rr_last_q;
    rf_we_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_wd_d   = rf_wd_q;
    busy_d    = busy_q;
    orphan_d  = orphan_q;

    if (xfer) begin
      rr_last_d = gnt_idx;
      // x0 results are consumed but never written; index/data keep their values.
      if (sel_rd != 5'd0) begin
        rf_we_d = 1'b1;
        rf_rd_d = sel_rd;
        rf_wd_d = sel_wd;
      end
    end

    // Clear on the edge that commits the write, so data is readable once busy drops.
    if (rf_we_q) begin
      busy_d[rf_rd_q] = 1'b0;
      if (!busy_q[rf_rd_q]) orphan_d = 1'b1;
    end
    // A same-cycle set to the cleared index wins over the clear.
    if (iss_fire) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers; asynchronous reset drops any pending write pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last_q <= SRC_MDU;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= 5'd0;
      rf_wd_q   <= '0;
      busy_q    <= 32'd0;
      orphan_q  <= 1'b0;
    end else begin
      rr_last_q <= rr_last_d;
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_wd_q   <= rf_wd_d;
      busy_q    <= busy_d;
      orphan_q  <= orphan_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_wd      = rf_wd_q;
  assign busy       = busy_q;
  assign orphan_err = orphan_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: reset, single write, contention,
// round-robin order, x0/orphan handling and issue stall.
module tb_regfile_wb_ctrl;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid, lsu_valid, mdu_valid;
  logic [4:0]      alu_rd, lsu_rd, mdu_rd;
  logic [XLEN-1:0] alu_wd, lsu_wd, mdu_wd;
  logic            alu_ready, lsu_ready, mdu_ready;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic            iss_ready;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic [31:0]     busy;
  logic            orphan_err;

  int checks = 0;
  int errors = 0;

  regfile_wb_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd), .lsu_ready(lsu_ready),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_wd(mdu_wd), .mdu_ready(mdu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .busy(busy), .orphan_err(orphan_err)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge (start of next cycle).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; lsu_valid = 0; mdu_valid = 0; iss_valid = 0;
    alu_rd = 0; lsu_rd = 0; mdu_rd = 0; iss_rd = 0;
    alu_wd = '0; lsu_wd = '0; mdu_wd = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;
  endtask

  task automatic test_reset_values();
    idle_inputs();
    reset = 1;
    #3;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we: got %b exp 0", rf_we); end
    checks++; if (rf_rd !== 5'd0) begin errors++; $display("FAIL rst_rf_rd: got %0d exp 0", rf_rd); end
    checks++; if (rf_wd !== 64'd0) begin errors++; $display("FAIL rst_rf_wd: got %h exp 0", rf_wd); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL rst_busy: got %h exp 0", busy); end
    checks++; if (orphan_err !== 1'b0) begin errors++; $display("FAIL rst_orphan: got %b exp 0", orphan_err); end
    tick();
    reset = 0;
    #1;
  endtask

  // Reset asserted mid-cycle while a write pulse is pending and busy=0xA0.
  task automatic test_reset();
    do_reset();
    iss_valid = 1; iss_rd = 5;
    tick();
    iss_rd = 7;
    tick();
    iss_valid = 0; alu_valid = 1; alu_rd = 5; alu_wd = 64'h1234;
    tick();
    alu_valid = 0;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL rstmid_pre_we: got %b exp 1", rf_we); end
    checks++; if (busy !== 32'h0000_00A0) begin errors++; $display("FAIL rstmid_pre_busy: got %h exp 000000a0", busy); end
    #2;
    reset = 1;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rstmid_we: got %b exp 0", rf_we); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL rstmid_busy: got %h exp 0", busy); end
    checks++; if (orphan_err !== 1'b0) begin errors++; $display("FAIL rstmid_orphan: got %b exp 0", orphan_err); end
    tick();
    reset = 0;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rstmid_post_we: got %b exp 0", rf_we); end
  endtask

  task automatic test_single_write();
    do_reset();
    // cycle 0
    iss_valid = 1; iss_rd = 5;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sw_iss_ready: got %b exp 1", iss_ready); end
    tick();
    // cycle 1
    iss_valid = 0; iss_rd = 0;
    checks++; if (busy[5] !== 1'b1) begin errors++; $display("FAIL sw_busy_c1: got %b exp 1", busy[5]); end
    tick();
    // cycle 2
    alu_valid = 1; alu_rd = 5; alu_wd = 64'hDEAD_BEEF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL sw_alu_ready: got %b exp 1", alu_ready); end
    checks++; if (busy[5] !== 1'b1) begin errors++; $display("FAIL sw_busy_c2: got %b exp 1", busy[5]); end
    tick();
    // cycle 3
    alu_valid = 0;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL sw_rf_we: got %b exp 1", rf_we); end
    checks++; if (rf_rd !== 5'd5) begin errors++; $display("FAIL sw_rf_rd: got %0d exp 5", rf_rd); end
    checks++; if (rf_wd !== 64'hDEAD_BEEF) begin errors++; $display("FAIL sw_rf_wd: got %h exp deadbeef", rf_wd); end
    checks++; if (busy[5] !== 1'b1) begin errors++; $display("FAIL sw_busy_c3: got %b exp 1", busy[5]); end
    tick();
    // cycle 4
    checks++; if (busy[5] !== 1'b0) begin errors++; $display("FAIL sw_busy_c4: got %b exp 0", busy[5]); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL sw_we_c4: got %b exp 0", rf_we); end
    checks++; if (rf_wd !== 64'hDEAD_BEEF) begin errors++; $display("FAIL sw_wd_hold: got %h exp deadbeef", rf_wd); end
    checks++; if (orphan_err !== 1'b0) begin errors++; $display("FAIL sw_orphan: got %b exp 0", orphan_err); end
  endtask

  // All three valid together, held until accepted: back-to-back writes.
  task automatic test_back_to_back();
    do_reset();
    alu_valid = 1; alu_rd = 1; alu_wd = 64'h11;
    lsu_valid = 1; lsu_rd = 2; lsu_wd = 64'h22;
    mdu_valid = 1; mdu_rd = 3; mdu_wd = 64'h33;
    #1;
    checks++; if ({alu_ready, lsu_ready, mdu_ready} !== 3'b100) begin errors++; $display("FAIL cont_c0_grant: got %b exp 100", {alu_ready, lsu_ready, mdu_ready}); end
    tick();
    alu_valid = 0;
    #1;
    checks++; if ({alu_ready, lsu_ready, mdu_ready} !== 3'b010) begin errors++; $display("FAIL cont_c1_grant: got %b exp 010", {alu_ready, lsu_ready, mdu_ready}); end
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd1 || rf_wd !== 64'h11) begin errors++; $display("FAIL cont_c1_wr: got we=%b rd=%0d wd=%h exp we=1 rd=1 wd=11", rf_we, rf_rd, rf_wd); end
    tick();
    lsu_valid = 0;
    #1;
    checks++; if ({alu_ready, lsu_ready, mdu_ready} !== 3'b001) begin errors++; $display("FAIL cont_c2_grant: got %b exp 001", {alu_ready, lsu_ready, mdu_ready}); end
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd2 || rf_wd !== 64'h22) begin errors++; $display("FAIL cont_c2_wr: got we=%b rd=%0d wd=%h exp we=1 rd=2 wd=22", rf_we, rf_rd, rf_wd); end
    tick();
    mdu_valid = 0;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wd !== 64'h33) begin errors++; $display("FAIL cont_c3_wr: got we=%b rd=%0d wd=%h exp we=1 rd=3 wd=33", rf_we, rf_rd, rf_wd); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL cont_c4_we: got %b exp 0", rf_we); end
  endtask

  task automatic test_round_robin();
    do_reset();
    lsu_valid = 1; lsu_rd = 4; lsu_wd = 64'h44;
    #1;
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL rr_lsu_grant: got %b exp 1", lsu_ready); end
    tick();
    lsu_valid = 0;
    alu_valid = 1; alu_rd = 6; alu_wd = 64'h66;
    mdu_valid = 1; mdu_rd = 8; mdu_wd = 64'h88;
    #1;
    checks++; if ({alu_ready, lsu_ready, mdu_ready} !== 3'b001) begin errors++; $display("FAIL rr_mdu_first: got %b exp 001", {alu_ready, lsu_ready, mdu_ready}); end
    tick();
    mdu_valid = 0;
    #1;
    checks++; if ({alu_ready, lsu_ready, mdu_ready} !== 3'b100) begin errors++; $display("FAIL rr_alu_second: got %b exp 100", {alu_ready, lsu_ready, mdu_ready}); end
    checks++; if (rf_rd !== 5'd8 || rf_wd !== 64'h88) begin errors++; $display("FAIL rr_mdu_wr: got rd=%0d wd=%h exp rd=8 wd=88", rf_rd, rf_wd); end
    tick();
    alu_valid = 0;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd6) begin errors++; $display("FAIL rr_alu_wr: got we=%b rd=%0d exp we=1 rd=6", rf_we, rf_rd); end
    tick();
  endtask

  task automatic test_x0_orphan();
    do_reset();
    alu_valid = 1; alu_rd = 0; alu_wd = 64'hAA;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_accept: got %b exp 1", alu_ready); end
    tick();
    alu_valid = 0;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we: got %b exp 0", rf_we); end
    tick();
    checks++; if (orphan_err !== 1'b0) begin errors++; $display("FAIL x0_orphan: got %b exp 0", orphan_err); end
    lsu_valid = 1; lsu_rd = 9; lsu_wd = 64'h99;
    #1;
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL orph_accept: got %b exp 1", lsu_ready); end
    tick();
    lsu_valid = 0;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd9) begin errors++; $display("FAIL orph_we: got we=%b rd=%0d exp we=1 rd=9", rf_we, rf_rd); end
    checks++; if (orphan_err !== 1'b0) begin errors++; $display("FAIL orph_early: got %b exp 0", orphan_err); end
    tick();
    checks++; if (orphan_err !== 1'b1) begin errors++; $display("FAIL orph_set: got %b exp 1", orphan_err); end
    tick();
    tick();
    checks++; if (orphan_err !== 1'b1) begin errors++; $display("FAIL orph_sticky: got %b exp 1", orphan_err); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL orph_busy: got %h exp 0", busy); end
  endtask

  task automatic test_issue_stall();
    do_reset();
    iss_valid = 1; iss_rd = 7;
    tick();
    // cycle 1: rd=7 pending
    #1;
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL stall_c1: got %b exp 0", iss_ready); end
    iss_rd = 0;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL stall_x0_ready: got %b exp 1", iss_ready); end
    iss_rd = 7; iss_valid = 0;
    tick();
    // cycle 2: write of rd=7 accepted
    alu_valid = 1; alu_rd = 7; alu_wd = 64'h77;
    #1;
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL stall_c2: got %b exp 0", iss_ready); end
    tick();
    // cycle 3: write pulse
    alu_valid = 0;
    #1;
    checks++; if (rf_we !== 1'b1 || iss_ready !== 1'b0) begin errors++; $display("FAIL stall_c3: got we=%b iss_ready=%b exp we=1 iss_ready=0", rf_we, iss_ready); end
    tick();
    // cycle 4: cleared
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL stall_c4: got %b exp 1", iss_ready); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL stall_busy: got %h exp 0", busy); end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset_values();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_round_robin();
    test_x0_orphan();
    test_issue_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-side controller for the integer register file. It arbitrates result traffic from three functional units (ALU, load/store unit, mul/div unit) onto the register file's single write port (`we`/`rd`/`wd`). It also keeps a 32-entry pending-write scoreboard that tells the issue stage when a destination register still has a result in flight. It sits between the execute units and the register file, and is the only driver of the register file write port.

## Interface

Parameters:
- `XLEN`, 64, data width; must match the register file.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: **asynchronous, active-high**; clears all state immediately.
- `alu_valid` / `lsu_valid` / `mdu_valid` in 1 each: the source holds a result; it must hold valid, rd and data stable until accepted.
- `alu_rd` / `lsu_rd` / `mdu_rd` in 5 each: destination register index.
- `alu_wd` / `lsu_wd` / `mdu_wd` in XLEN each: result data.
- `alu_ready` / `lsu_ready` / `mdu_ready` out 1 each: grant; the transfer happens on a cycle with valid&&ready.
- `iss_valid` in 1: the issue stage presents an instruction that writes `iss_rd`.
- `iss_rd` in 5: destination of the issuing instruction.
- `iss_ready` out 1: combinational; high when `iss_rd`==0 or `busy[iss_rd]`==0.
- `rf_we` out 1: register file write enable (registered).
- `rf_rd` out 5: register file write index (registered).
- `rf_wd` out XLEN: register file write data (registered).
- `busy` out 32: pending-write scoreboard; bit 0 is always 0.
- `orphan_err` out 1: sticky flag for a writeback to a non-pending register.

## Operation

- **Arbitration**
  - Round-robin over sources 0=ALU, 1=LSU, 2=MDU. At most one grant per cycle.
  - `ready_i` is combinational from the three valids and `rr_last`.
  - Priority order is `rr_last`+1, +2, +3 (mod 3). `rr_last` updates to the granted index on each transfer.
  - `rr_last` resets to 2, so the order after reset is ALU, LSU, MDU.
  - A source that is not valid is never granted. `ready` must not depend on that source's own data.
- **Write port**
  - A transfer in cycle N loads `rf_rd`/`rf_wd` from the granted source and sets `rf_we` for cycle N+1.
  - If the transferred rd==0, `rf_we` is 0 in N+1. The transfer is still accepted and consumed.
  - `rf_we` is a one-cycle pulse per transfer. Back-to-back transfers give a continuous `rf_we`.
  - `rf_rd`/`rf_wd` hold their last values when `rf_we`=0.
- **Scoreboard**
  - Set: `iss_valid`&&`iss_ready`&&`iss_rd`!=0 sets `busy[iss_rd]` at the cycle-end edge.
  - Clear: a cycle with `rf_we`=1 clears `busy[rf_rd]` at the edge that also commits the write in the register file. The data is therefore readable from the register file in the first cycle `busy` is low.
  - Set and clear on the same index in the same cycle: set wins. This is reachable only through an orphan write.
  - Clearing a bit that is not set is a no-op.
- **Orphan detection**
  - `orphan_err` is set when `rf_we`=1 and `busy[rf_rd]`=0. It stays set until reset.
  - The write still proceeds.

## Timing

- **Reset values:** `rf_we`=0, `rf_rd`=0, `rf_wd`=0, `busy`=0, `orphan_err`=0, `rr_last`=2.
  - `ready`/`iss_ready` are combinational, so they follow the inputs during reset. Transfers during reset are discarded.
- **Latency:**
  - Accept to register-file write enable: 1 cycle.
  - Accept to `busy` low: 2 cycles.
- **Throughput:** one write per cycle, sustained.
- **Reset mid-operation:** a pulse pending in the output register is dropped, not written. All `busy` bits clear.
- **Issue stall:** `iss_ready`=0 for the whole window from the set edge until the clear edge.

## Test plan

- **Reset:** assert `reset` while `rf_we`=1 and `busy`=0x0000_00A0 -> `rf_we`=0, `busy`=0 and `orphan_err`=0 immediately, with no clock edge needed.
- **Single write:**
  - Stimulus: issue rd=5 in cycle 0; ALU valid with rd=5, wd=0xDEADBEEF in cycle 2.
  - Response: `busy[5]`=1 in cycles 1..3; `alu_ready`=1 in cycle 2; `rf_we`=1, `rf_rd`=5, `rf_wd`=0xDEADBEEF in cycle 3; `busy[5]`=0 in cycle 4.
- **Contention:** all three sources valid from cycle 0 with rd=1/2/3 and held until accepted -> grants ALU (c0), LSU (c1), MDU (c2); `rf_we` high in cycles 1..3 with `rf_rd` 1, 2, 3.
- **Round-robin order:** after an LSU-only grant, ALU and MDU are valid together -> MDU is granted first, then ALU.
- **x0 and orphan:**
  - ALU write to rd=0 -> accepted, `rf_we` stays 0, `orphan_err`=0.
  - LSU write to un-issued rd=9 -> `rf_we`=1 in the next cycle and `orphan_err`=1 from the following cycle onward.
- **Issue stall:** issue rd=7, then present `iss_rd`=7 again -> `iss_ready`=0 until the cycle after the rd=7 write pulse. `iss_rd`=0 is always ready.
